// File: rtl/spi_pkg.sv
// Shared encodings for the SPI slave controller: FSM states and command codes.
package spi_pkg;

  // Debug-visible state encoding, exported on state_o.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'b000,
    ST_CHK       = 3'b001,
    ST_WRITE     = 3'b010,
    ST_READ_ADD  = 3'b011,
    ST_READ_DATA = 3'b100,
    ST_TX_WAIT   = 3'b101,
    ST_TX_SHIFT  = 3'b110,
    ST_DONE      = 3'b111
  } state_e;

  // Two-bit command field carried in the top bits of every frame.
  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  // True when the received command is legal for the branch the FSM took
  // after seeing the first frame bit.
  function automatic logic cmd_ok(input state_e st, input logic [1:0] cmd);
    logic ok;
    ok = 1'b0;
    case (st)
      ST_WRITE:     ok = (cmd == CMD_WR_ADDR) || (cmd == CMD_WR_DATA);
      ST_READ_ADD:  ok = (cmd == CMD_RD_ADDR);
      ST_READ_DATA: ok = (cmd == CMD_RD_DATA);
      default:      ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/spi_tx_serializer.sv
// MSB-first parallel-to-serial converter driving the registered MISO line.
// A load presents the MSB on the next cycle; the remaining bits follow one
// per clock, after which miso returns to 0 and done is raised for one cycle.
module spi_tx_serializer #(
  parameter int PAYLOAD_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic                 clear,
  input  logic [PAYLOAD_W-1:0] data,
  output logic                 miso,
  output logic                 done
);

  localparam int BC_W = $clog2(PAYLOAD_W) + 1;

  logic [PAYLOAD_W-1:0] sreg_q;
  logic [BC_W-1:0]      left_q;
  logic                 busy_q;
  logic                 miso_q;

  // Shift engine: clear has priority, then load, then one bit per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg_q <= '0;
      left_q <= '0;
      busy_q <= 1'b0;
      miso_q <= 1'b0;
    end else if (clear) begin
      sreg_q <= '0;
      left_q <= '0;
      busy_q <= 1'b0;
      miso_q <= 1'b0;
    end else if (load) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values, independent of statement order.
      miso_q <= data[PAYLOAD_W-1];
      sreg_q <= data << 1;
      left_q <= BC_W'(PAYLOAD_W - 1);
      busy_q <= 1'b1;
    end else if (busy_q) begin
      if (left_q == '0) begin
        miso_q <= 1'b0;
        busy_q <= 1'b0;
      end else begin
        miso_q <= sreg_q[PAYLOAD_W-1];
        sreg_q <= sreg_q << 1;
        left_q <= left_q - 1'b1;
      end
    end
  end

  assign miso = miso_q;
  assign done = busy_q && (left_q == '0);

endmodule

// File: rtl/spi_slave_ctrl_p.sv
// SPI slave front-end: deframes {cmd, payload} words from MOSI, hands them to
// the memory as a one-cycle rx_valid pulse, checks that the command matches
// the branch taken on the first bit, and returns read data on MISO with a
// bounded wait for the memory's tx_valid.
module spi_slave_ctrl_p
  import spi_pkg::*;
#(
  parameter int PAYLOAD_W   = 8,
  parameter int TX_WAIT_MAX = 15,
  parameter int CNT_W       = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ss_n,
  input  logic                 mosi,
  output logic                 miso,
  output logic [PAYLOAD_W+1:0] rx_data,
  output logic                 rx_valid,
  input  logic [PAYLOAD_W-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 frame_err,
  output logic [2:0]           state_o
);

  localparam int FRAME_W = PAYLOAD_W + 2;
  localparam int WAIT_W  = $clog2(TX_WAIT_MAX + 1);

  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(FRAME_W - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TX_WAIT_MAX - 1);

  state_e               state_q, state_d;
  logic [FRAME_W-2:0]   shift_q;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [WAIT_W-1:0]    wait_cnt_q, wait_cnt_d;
  logic                 rd_addr_pend_q;
  logic [FRAME_W-1:0]   rx_data_q;
  logic                 rx_valid_q;
  logic                 frame_err_q;

  logic [FRAME_W-1:0]   new_word;
  logic                 capture;
  logic                 frame_match;
  logic                 frame_mismatch;
  logic                 tx_load;
  logic                 tx_timeout;
  logic                 tx_done;

  // Word as it stands once the current mosi bit has been shifted in.
  assign new_word = {shift_q, mosi};

  // Next-state and per-cycle strobes for the deframer / read-return FSM.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d        = state_q;
    capture        = 1'b0;
    frame_match    = 1'b0;
    frame_mismatch = 1'b0;
    tx_load        = 1'b0;
    tx_timeout     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!ss_n) state_d = ST_CHK;
      end

      // First frame bit is cmd[1]: 0 is a write, 1 is a read whose phase
      // depends on whether an address is already pending.
      ST_CHK: begin
        capture = 1'b1;
        if (ss_n)                state_d = ST_IDLE;
        else if (!mosi)          state_d = ST_WRITE;
        else if (rd_addr_pend_q) state_d = ST_READ_DATA;
        else                     state_d = ST_READ_ADD;
      end

      // The last bit completes the frame even if ss_n rises on that edge.
      ST_WRITE, ST_READ_ADD, ST_READ_DATA: begin
        capture = 1'b1;
        if (bit_cnt_q == LAST_CNT) begin
          if (cmd_ok(state_q, new_word[FRAME_W-1 -: 2])) frame_match    = 1'b1;
          else                                           frame_mismatch = 1'b1;
          if (ss_n)                                         state_d = ST_IDLE;
          else if (frame_match && state_q == ST_READ_DATA)  state_d = ST_TX_WAIT;
          else                                              state_d = ST_DONE;
        end else if (ss_n) begin
          state_d = ST_IDLE;
        end
      end

      ST_TX_WAIT: begin
        if (ss_n) begin
          state_d = ST_IDLE;
        end else if (tx_valid) begin
          tx_load = 1'b1;
          state_d = ST_TX_SHIFT;
        end else if (wait_cnt_q == WAIT_LAST) begin
          tx_timeout = 1'b1;
          state_d    = ST_DONE;
        end
      end

      ST_TX_SHIFT: begin
        if (ss_n)         state_d = ST_IDLE;
        else if (tx_done) state_d = ST_DONE;
      end

      ST_DONE: begin
        if (ss_n) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    // Bit count follows the frame: 1 after CHK, cleared whenever the FSM
    // leaves the shifting states (completion or abort).
    if (state_d == ST_WRITE || state_d == ST_READ_ADD || state_d == ST_READ_DATA)
      bit_cnt_d = bit_cnt_q + 1'b1;
    else
      bit_cnt_d = '0;

    // Wait counter runs only while we stay in TX_WAIT.
    if (state_q == ST_TX_WAIT && state_d == ST_TX_WAIT)
      wait_cnt_d = wait_cnt_q + 1'b1;
    else
      wait_cnt_d = '0;
  end

  // FSM state and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Frame capture, handshake pulses and read-phase tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q        <= '0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      frame_err_q    <= 1'b0;
      rd_addr_pend_q <= 1'b0;
    end else begin
      if (capture) shift_q <= new_word[FRAME_W-2:0];
      rx_valid_q  <= frame_match;
      frame_err_q <= frame_mismatch | tx_timeout;
      if (frame_match) begin
        rx_data_q <= new_word;
        if (state_q == ST_READ_ADD)  rd_addr_pend_q <= 1'b1;
        if (state_q == ST_READ_DATA) rd_addr_pend_q <= 1'b0;
      end
    end
  end

  // MISO path; deselect flushes it so a partial read never leaks out.
  spi_tx_serializer #(
    .PAYLOAD_W (PAYLOAD_W)
  ) u_tx (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (tx_load),
    .clear (ss_n),
    .data  (tx_data),
    .miso  (miso),
    .done  (tx_done)
  );

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_spi_slave_ctrl_p.sv
// Self-checking bench for spi_slave_ctrl_p: directed frame table, random
// frames against a frame-level reference model, and an async reset sequence.
module tb_spi_slave_ctrl_p;

  localparam int PW = 8;
  localparam logic [2:0] S_IDLE     = 3'b000;
  localparam logic [2:0] S_CHK      = 3'b001;
  localparam logic [2:0] S_TX_WAIT  = 3'b101;
  localparam logic [2:0] S_TX_SHIFT = 3'b110;
  localparam logic [2:0] S_DONE     = 3'b111;

  logic          clk;
  logic          rst_n;
  logic          ss_n;
  logic          mosi;
  logic          miso;
  logic [PW+1:0] rx_data;
  logic          rx_valid;
  logic [PW-1:0] tx_data;
  logic          tx_valid;
  logic          frame_err;
  logic [2:0]    state_o;

  spi_slave_ctrl_p #(
    .PAYLOAD_W   (PW),
    .TX_WAIT_MAX (15),
    .CNT_W       (5)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ss_n      (ss_n),
    .mosi      (mosi),
    .miso      (miso),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .frame_err (frame_err),
    .state_o   (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int frame_no = 0;

  // Reference model state: pending read address flag and last delivered word.
  bit         m_pend = 1'b0;
  logic [9:0] m_rxd  = '0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // nbits < 10 aborts after that many bits; tx_d in 1..14 raises tx_valid on
  // that TX_WAIT cycle, otherwise never; abort_sel > 0 deselects during TX.
  typedef struct {
    logic [1:0] cmd;
    logic [7:0] pay;
    int         nbits;
    bit         rise_last;
    int         tx_d;
    logic [7:0] txd;
    int         abort_sel;
  } frame_t;

  typedef struct {
    frame_t     f;
    logic [9:0] exp_rxd;
    int         exp_rxv;
    int         exp_err;
  } vec_t;

  // Drive one frame and check every cycle against expectations derived from
  // the frame rules: pulse timing, MISO bit schedule, held rx_data.
  task automatic run_frame(input frame_t f, output int n_rxv, output int n_err);
    logic       ss_a[64];
    logic       mosi_a[64];
    logic       txv_a[64];
    bit         e_rxv[64];
    bit         e_err[64];
    bit         e_miso[64];
    bit         st_chk[64];
    logic [2:0] e_st[64];
    logic [9:0] word;
    logic [9:0] new_rxd;
    int         kind;
    bit         ok, full, rise;
    int         end_s, nat_end;

    n_rxv = 0;
    n_err = 0;
    frame_no++;
    word = {f.cmd, f.pay};
    for (int s = 0; s < 64; s++) begin
      ss_a[s] = 1'b1; mosi_a[s] = 1'($urandom); txv_a[s] = 1'b0;
      e_rxv[s] = 1'b0; e_err[s] = 1'b0; e_miso[s] = 1'b0;
      st_chk[s] = 1'b0; e_st[s] = S_IDLE;
    end

    // 0 = write branch, 1 = read address, 2 = read data.
    kind = !f.cmd[1] ? 0 : (m_pend ? 2 : 1);
    ok   = (kind == 0) || (kind == 1 && f.cmd == 2'b10) || (kind == 2 && f.cmd == 2'b11);
    full = (f.nbits >= 10);
    rise = full && f.rise_last && ok;

    for (int s = 0; s <= 10; s++) begin
      ss_a[s]  = 1'b0;
      txv_a[s] = 1'($urandom_range(0, 1));
    end
    for (int k = 1; k <= f.nbits && k <= 10; k++) mosi_a[k] = word[10-k];
    st_chk[1] = 1'b1; e_st[1] = S_CHK;

    if (!full) begin
      end_s = f.nbits + 1;
      for (int s = end_s; s <= 10; s++) ss_a[s] = 1'b1;
    end else begin
      e_rxv[11] = ok;
      e_err[11] = !ok;
      if (rise) begin
        ss_a[10] = 1'b1;
        end_s = 10;
      end else if (ok && kind == 2) begin
        st_chk[11] = 1'b1; e_st[11] = S_TX_WAIT;
        if (f.tx_d >= 1 && f.tx_d <= 14) begin
          txv_a[10 + f.tx_d] = 1'b1;
          for (int i = 0; i < 8; i++) e_miso[11 + f.tx_d + i] = f.txd[7-i];
          nat_end = 19 + f.tx_d;
          st_chk[nat_end] = 1'b1; e_st[nat_end] = S_DONE;
        end else begin
          e_err[26] = 1'b1;
          nat_end = 26;
        end
        end_s = nat_end;
        if (f.abort_sel > 0) begin
          end_s = 11 + (f.abort_sel % (nat_end - 11));
          for (int s = end_s + 1; s < 64; s++) begin
            e_rxv[s] = 1'b0; e_err[s] = 1'b0; e_miso[s] = 1'b0; st_chk[s] = 1'b0;
          end
        end
        for (int s = 11; s < end_s; s++) ss_a[s] = 1'b0;
      end else begin
        st_chk[11] = 1'b1; e_st[11] = S_DONE;
        end_s = 11 + $urandom_range(0, 2);
        for (int s = 11; s < end_s; s++) ss_a[s] = 1'b0;
      end
    end
    st_chk[end_s + 1] = 1'b1; e_st[end_s + 1] = S_IDLE;

    new_rxd = (full && ok) ? word : m_rxd;

    for (int s = 0; s <= end_s + 1; s++) begin
      @(negedge clk);
      check($sformatf("f%0d s%0d rx_valid", frame_no, s), 32'(rx_valid), 32'(e_rxv[s]));
      check($sformatf("f%0d s%0d frame_err", frame_no, s), 32'(frame_err), 32'(e_err[s]));
      check($sformatf("f%0d s%0d miso", frame_no, s), 32'(miso), 32'(e_miso[s]));
      check($sformatf("f%0d s%0d rx_data", frame_no, s), 32'(rx_data),
            32'((s >= 11) ? new_rxd : m_rxd));
      if (st_chk[s])
        check($sformatf("f%0d s%0d state", frame_no, s), 32'(state_o), 32'(e_st[s]));
      n_rxv += int'(rx_valid);
      n_err += int'(frame_err);
      ss_n     = ss_a[s];
      mosi     = mosi_a[s];
      tx_valid = txv_a[s];
      tx_data  = txv_a[s] ? f.txd : 8'($urandom);
    end

    m_rxd = new_rxd;
    if (full && ok && kind == 1) m_pend = 1'b1;
    if (full && ok && kind == 2) m_pend = 1'b0;
  endtask

  vec_t   vecs[12];
  frame_t fr;
  int     got_rxv, got_err;
  logic [9:0] rd_word;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{'{2'b00, 8'h3C, 10, 1'b0, -1, 8'h00, 0}, 10'h03C, 1, 0};
    vecs[1]  = '{'{2'b01, 8'hA5, 10, 1'b0, -1, 8'h00, 0}, 10'h1A5, 1, 0};
    vecs[2]  = '{'{2'b10, 8'h12, 10, 1'b0, -1, 8'h00, 0}, 10'h212, 1, 0};
    vecs[3]  = '{'{2'b11, 8'h00, 10, 1'b0,  2, 8'hC3, 0}, 10'h300, 1, 0};
    vecs[4]  = '{'{2'b01, 8'hFF,  5, 1'b0, -1, 8'h00, 0}, 10'h300, 0, 0};
    vecs[5]  = '{'{2'b10, 8'h55, 10, 1'b0, -1, 8'h00, 0}, 10'h255, 1, 0};
    vecs[6]  = '{'{2'b10, 8'h77, 10, 1'b0, -1, 8'h00, 0}, 10'h255, 0, 1};
    vecs[7]  = '{'{2'b11, 8'h0F, 10, 1'b0, -1, 8'h00, 0}, 10'h30F, 1, 1};
    vecs[8]  = '{'{2'b00, 8'h81, 10, 1'b1, -1, 8'h00, 0}, 10'h081, 1, 0};
    vecs[9]  = '{'{2'b11, 8'h5A, 10, 1'b0, -1, 8'h00, 0}, 10'h081, 0, 1};
    vecs[10] = '{'{2'b10, 8'h33, 10, 1'b0, -1, 8'h00, 0}, 10'h233, 1, 0};
    vecs[11] = '{'{2'b11, 8'h44, 10, 1'b0, 14, 8'h5A, 0}, 10'h344, 1, 0};

    rst_n = 1'b0; ss_n = 1'b1; mosi = 1'b0; tx_valid = 1'b0; tx_data = '0;
    repeat (3) @(negedge clk);
    check("reset state", 32'(state_o), 32'(S_IDLE));
    check("reset miso", 32'(miso), 32'd0);
    check("reset rx_valid", 32'(rx_valid), 32'd0);
    check("reset frame_err", 32'(frame_err), 32'd0);
    check("reset rx_data", 32'(rx_data), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed frames, chained so read-address/read-data pairs line up.
    for (int v = 0; v < 12; v++) begin
      run_frame(vecs[v].f, got_rxv, got_err);
      check($sformatf("vec%0d rx_data", v), 32'(rx_data), 32'(vecs[v].exp_rxd));
      check($sformatf("vec%0d rx_valid count", v), 32'(got_rxv), 32'(vecs[v].exp_rxv));
      check($sformatf("vec%0d frame_err count", v), 32'(got_err), 32'(vecs[v].exp_err));
    end

    // Random frames, biased toward commands that match the pending phase.
    repeat (40) begin
      fr.cmd = 2'($urandom);
      if ($urandom_range(0, 1) == 1 && m_pend) fr.cmd = 2'b11;
      fr.pay       = 8'($urandom);
      fr.nbits     = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 9)) : 10;
      fr.rise_last = ($urandom_range(0, 7) == 0);
      fr.tx_d      = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(1, 14));
      fr.txd       = 8'($urandom);
      fr.abort_sel = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 1000)) : 0;
      run_frame(fr, got_rxv, got_err);
    end

    // Async reset in the middle of TX_SHIFT.
    fr = '{2'b10, 8'h40, 10, 1'b0, -1, 8'h00, 0};
    run_frame(fr, got_rxv, got_err);
    rd_word = 10'h301;
    @(negedge clk); ss_n = 1'b0; tx_valid = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk); mosi = rd_word[10-k];
    end
    @(negedge clk);
    check("rst seq rx_valid", 32'(rx_valid), 32'd1);
    check("rst seq rx_data", 32'(rx_data), 32'h301);
    tx_valid = 1'b1; tx_data = 8'hB0;
    @(negedge clk);
    tx_valid = 1'b0;
    check("rst seq miso bit7", 32'(miso), 32'd1);
    check("rst seq state shift", 32'(state_o), 32'(S_TX_SHIFT));
    @(negedge clk);
    check("rst seq miso bit6", 32'(miso), 32'd0);
    @(negedge clk);
    check("rst seq miso bit5", 32'(miso), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst async miso", 32'(miso), 32'd0);
    check("rst async state", 32'(state_o), 32'(S_IDLE));
    check("rst async rx_data", 32'(rx_data), 32'd0);
    @(negedge clk);
    ss_n = 1'b1; rst_n = 1'b1;
    m_pend = 1'b0; m_rxd = '0;
    @(negedge clk);

    // After reset no address is pending, so a read-address frame is accepted.
    fr = '{2'b10, 8'h99, 10, 1'b0, -1, 8'h00, 0};
    run_frame(fr, got_rxv, got_err);
    check("post reset rd addr rx_valid", 32'(got_rxv), 32'd1);
    check("post reset rd addr rx_data", 32'(rx_data), 32'h299);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
